window_3x3_gen: RTL and testbench

WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

---
 rtl/median_filter_pkg.sv | 11 +
 rtl/bram.sv | 38 +++
 rtl/window_3x3_gen.sv | 173 +++++++++++++++++
 tb/tb_window_3x3_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/median_filter_pkg.sv
// Shared definitions for the median-filter pipeline.
//   DEFAULT_DATA_WIDTH : default pixel width in bits
//   window_t           : nine pixels, element k = row*3 + col, element 0 is
//                        the oldest (top-left) pixel and element 8 the newest
package median_filter_pkg;

    localparam int DEFAULT_DATA_WIDTH = 12;

    typedef logic [8:0][DEFAULT_DATA_WIDTH-1:0] window_t;

endpackage

// File: rtl/bram.sv
// Simple dual-port block RAM with a registered read.
//   clk       : clock
//   wr_en_i   : write enable
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_en_i   : read enable; rd_data_o updates one cycle later
//   rd_addr_i : read address
//   rd_data_o : read data (holds its value while rd_en_i is low)
// A read and a write to the same address in one cycle return the old data.
// Contents are not reset.
module bram #(
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int BRAM_DATA_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       wr_en_i,
    input  logic [BRAM_ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [BRAM_DATA_WIDTH-1:0] wr_data_i,
    input  logic                       rd_en_i,
    input  logic [BRAM_ADDR_WIDTH-1:0] rd_addr_i,
    output logic [BRAM_DATA_WIDTH-1:0] rd_data_o
);

    logic [BRAM_DATA_WIDTH-1:0] mem_q [2**BRAM_ADDR_WIDTH];
    logic [BRAM_DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/window_3x3_gen.sv
// 3x3 sliding-window generator for a raster pixel stream.
//   clk, rst_n       : clock, asynchronous active-low reset
//   pixel_i          : input pixel, raster order
//   pixel_valid_i    : pixel_i is valid
//   pixel_ready_o    : block accepts pixel_i this cycle
//   window_o         : 3x3 window, slice k = row*3+col, slice 0 oldest (top-left)
//   window_valid_o   : window_o is valid
//   window_ready_i   : downstream accepts window_o
// Only fully interior windows are produced (no border padding), so a frame
// yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows through a 2-entry output FIFO.
module window_3x3_gen
    import median_filter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   pixel_i,
    input  logic                    pixel_valid_i,
    output logic                    pixel_ready_o,
    output logic [9*DATA_WIDTH-1:0] window_o,
    output logic                    window_valid_o,
    input  logic                    window_ready_i
);

    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    typedef logic [8:0][DATA_WIDTH-1:0] win_t;

    logic                  accept;
    logic                  pop;
    logic                  push;
    logic [2:0]            occupancy;
    logic [ADDR_WIDTH-1:0] col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic                  s1_valid_q;
    logic                  s1_push_q;
    logic [ADDR_WIDTH-1:0] s1_col_q;
    logic [DATA_WIDTH-1:0] s1_pixel_q;
    logic [DATA_WIDTH-1:0] lb0_rd;
    logic [DATA_WIDTH-1:0] lb1_rd;
    win_t                  win_q, win_d;
    win_t                  fifo_q [2];
    win_t                  fifo_d [2];
    logic [1:0]            out_cnt_q, out_cnt_d;

    assign window_valid_o = (out_cnt_q != 2'd0);
    assign pop            = window_valid_o & window_ready_i;
    // Count the window still in flight in s1 so the FIFO can never overflow.
    assign occupancy      = {1'b0, out_cnt_q} + {2'b0, s1_valid_q} - {2'b0, pop};
    assign pixel_ready_o  = (occupancy <= 3'd1);
    assign accept         = pixel_valid_i & pixel_ready_o;
    assign push           = s1_valid_q & s1_push_q;
    assign window_o       = fifo_q[0];

    // lb0 holds line row-1; it is read and overwritten at the same column.
    bram #(
        .BRAM_ADDR_WIDTH(ADDR_WIDTH),
        .BRAM_DATA_WIDTH(DATA_WIDTH)
    ) u_lb0 (
        .clk       (clk),
        .wr_en_i   (accept),
        .wr_addr_i (col_q),
        .wr_data_i (pixel_i),
        .rd_en_i   (accept),
        .rd_addr_i (col_q),
        .rd_data_o (lb0_rd)
    );

    // lb1 holds line row-2; it receives lb0's old data one cycle later.
    bram #(
        .BRAM_ADDR_WIDTH(ADDR_WIDTH),
        .BRAM_DATA_WIDTH(DATA_WIDTH)
    ) u_lb1 (
        .clk       (clk),
        .wr_en_i   (s1_valid_q),
        .wr_addr_i (s1_col_q),
        .wr_data_i (lb0_rd),
        .rd_en_i   (accept),
        .rd_addr_i (col_q),
        .rd_data_o (lb1_rd)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + ADDR_WIDTH'(1);
            end
        end
    end

    // Window shift: each row moves one column left, new column enters at col 2
    // as {row0 = line row-2, row1 = line row-1, row2 = current pixel}.
    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_shift
        assign win_d[gi*3 + 0] = win_q[gi*3 + 1];
        assign win_d[gi*3 + 1] = win_q[gi*3 + 2];
    end
    assign win_d[2] = lb1_rd;
    assign win_d[5] = lb0_rd;
    assign win_d[8] = s1_pixel_q;

    // Two-entry FIFO, fifo_q[0] is the head; the shifted window is pushed
    // directly so it appears one cycle after s1.
    always_comb begin
        out_cnt_d = out_cnt_q;
        fifo_d[0] = fifo_q[0];
        fifo_d[1] = fifo_q[1];
        case ({push, pop})
            2'b10: begin
                if (out_cnt_q == 2'd0) fifo_d[0] = win_d;
                else                   fifo_d[1] = win_d;
                out_cnt_d = out_cnt_q + 2'd1;
            end
            2'b01: begin
                fifo_d[0] = fifo_q[1];
                out_cnt_d = out_cnt_q - 2'd1;
            end
            2'b11: begin
                if (out_cnt_q == 2'd1) begin
                    fifo_d[0] = win_d;
                end else begin
                    fifo_d[0] = fifo_q[1];
                    fifo_d[1] = win_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_push_q  <= 1'b0;
            s1_col_q   <= '0;
            s1_pixel_q <= '0;
            win_q      <= '0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            out_cnt_q  <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            s1_valid_q <= accept;
            // Only interior positions complete a window; rows 0-1 and cols 0-1
            // would mix in other lines or stale line-buffer contents.
            s1_push_q  <= accept && (row_q >= ROW_W'(2)) && (col_q >= ADDR_WIDTH'(2));
            if (accept) begin
                s1_col_q   <= col_q;
                s1_pixel_q <= pixel_i;
            end
            if (s1_valid_q) begin
                win_q <= win_d;
            end
            fifo_q[0] <= fifo_d[0];
            fifo_q[1] <= fifo_d[1];
            out_cnt_q <= out_cnt_d;
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
module tb_window_3x3_gen;
    import median_filter_pkg::*;

    localparam int DW = DEFAULT_DATA_WIDTH;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int AW = 3;
    localparam int WIN_PER_FRAME = (W - 2) * (H - 2);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [DW-1:0]   pixel_i = '0;
    logic            pixel_valid_i = 1'b0;
    logic            pixel_ready_o;
    logic [9*DW-1:0] window_o;
    logic            window_valid_o;
    logic            window_ready_i = 1'b0;

    always #5 clk = ~clk;

    window_3x3_gen #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pixel_i        (pixel_i),
        .pixel_valid_i  (pixel_valid_i),
        .pixel_ready_o  (pixel_ready_o),
        .window_o       (window_o),
        .window_valid_o (window_valid_o),
        .window_ready_i (window_ready_i)
    );

    typedef struct {
        window_t w;
        int      cyc;
    } obs_t;

    typedef struct {
        int acc_idx;   // accept index of the completing pixel
        int px [9];    // expected window contents
    } vec_t;

    int      total = 0;
    int      bad = 0;
    int      cyc = 0;
    int      n_pop = 0;
    int      n_acc = 0;
    int      m_row = 0;
    int      m_col = 0;
    int      img [H][W];
    window_t exp_q [$];
    obs_t    obs_q [$];
    bit      hold_q = 1'b0;
    window_t hold_w;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference: store the frame as a 2-D image; every interior pixel
    // completes the window made of the 3x3 block ending at it.
    task automatic model_accept(input logic [DW-1:0] p);
        window_t w;
        img[m_row][m_col] = int'(p);
        if (m_row >= 2 && m_col >= 2) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w[r*3 + c] = DW'(img[m_row - 2 + r][m_col - 2 + c]);
            exp_q.push_back(w);
        end
        n_acc++;
        m_col++;
        if (m_col == W) begin
            m_col = 0;
            m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end
    endtask

    task automatic model_reset();
        m_row = 0;
        m_col = 0;
        exp_q.delete();
        hold_q = 1'b0;
    endtask

    // One clock: sample at the falling edge, then return #1 after the rising edge.
    task automatic step();
        @(negedge clk);
        if (hold_q) begin
            chk("hold_valid", window_valid_o, 1);
            chk("hold_data", window_o, hold_w);
        end
        hold_q = window_valid_o && !window_ready_i;
        hold_w = window_o;
        if (window_valid_o && window_ready_i) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_window: got %0h want none", window_o);
            end else begin
                window_t e = exp_q.pop_front();
                chk("window", window_o, e);
                $display("window %0d at cycle %0d: %0h", n_pop, cyc, window_o);
            end
            obs_q.push_back('{window_o, cyc});
        end
        if (pixel_valid_i && pixel_ready_o) model_accept(pixel_i);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Feed n accepted pixels; directed pixels are row*16+col+offset.
    task automatic stream(input bit rnd, input int offset, input int n, input int budget);
        int start = n_acc;
        int k = 0;
        while (n_acc - start < n && k < budget) begin
            pixel_valid_i  = rnd ? ($urandom_range(3) != 0) : 1'b1;
            window_ready_i = rnd ? ($urandom_range(2) != 0) : 1'b1;
            pixel_i        = rnd ? DW'($urandom) : DW'(m_row * 16 + m_col + offset);
            step();
            k++;
        end
        chk("stream_budget", (n_acc - start >= n), 1);
    endtask

    task automatic drain(input int n);
        pixel_valid_i  = 1'b0;
        window_ready_i = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t    vecs [6];
        window_t ew;
        int      s;
        int      p0;

        vecs[0] = '{12, '{ 0,  1,  2, 16, 17, 18, 32, 33, 34}};
        vecs[1] = '{13, '{ 1,  2,  3, 17, 18, 19, 33, 34, 35}};
        vecs[2] = '{14, '{ 2,  3,  4, 18, 19, 20, 34, 35, 36}};
        vecs[3] = '{17, '{16, 17, 18, 32, 33, 34, 48, 49, 50}};
        vecs[4] = '{18, '{17, 18, 19, 33, 34, 35, 49, 50, 51}};
        vecs[5] = '{19, '{18, 19, 20, 34, 35, 36, 50, 51, 52}};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_valid", window_valid_o, 0);
        chk("reset_ready", pixel_ready_o, 1);
        chk("reset_window", window_o, 0);

        // 5x4 frame, pixel = row*16+col, constant ready
        cyc = 0;
        obs_q.delete();
        stream(1'b0, 0, W * H, 40);
        chk("dir_rate", cyc, W * H);
        drain(4);
        chk("dir_count", obs_q.size(), WIN_PER_FRAME);
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 9; k++) ew[k] = DW'(vecs[i].px[k]);
            if (i < obs_q.size()) begin
                chk("dir_win", obs_q[i].w, ew);
                chk("dir_latency", obs_q[i].cyc, vecs[i].acc_idx + 2);
            end
        end

        // Backpressure: ready low for 10 cycles starting at row 2
        stream(1'b0, 'h100, 2 * W, 20);
        s = n_acc;
        window_ready_i = 1'b0;
        pixel_valid_i  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pixel_i = DW'(m_row * 16 + m_col + 'h100);
            step();
        end
        chk("bp_accepts", n_acc - s, 4);
        chk("bp_ready", pixel_ready_o, 0);
        chk("bp_valid", window_valid_o, 1);
        stream(1'b0, 'h100, W * H - 2 * W - 4, 30);
        drain(4);
        chk("bp_lost", exp_q.size(), 0);

        // Random valid/ready over 3 back-to-back frames
        p0 = n_pop;
        stream(1'b1, 0, 3 * W * H, 2000);
        drain(6);
        chk("rnd_count", n_pop - p0, 3 * WIN_PER_FRAME);
        chk("rnd_lost", exp_q.size(), 0);

        // Reset pulse at frame pixel (2,3)
        stream(1'b0, 'h200, 2 * W + 3, 30);
        pixel_valid_i  = 1'b0;
        window_ready_i = 1'b0;
        step();
        step();
        chk("pre_rst_valid", window_valid_o, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_valid_async", window_valid_o, 0);
        chk("rst_ready", pixel_ready_o, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        p0 = n_pop;
        stream(1'b0, 'h400, W * H, 40);
        drain(4);
        chk("post_rst_count", n_pop - p0, WIN_PER_FRAME);
        chk("post_rst_lost", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
